// File: rtl/exec_pkg.sv
// Shared opcode, state and flag definitions for the execute stage.
package exec_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_NOP = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for all single-cycle opcodes.
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              v
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
                v      = (a[DATA_W-1] == b[DATA_W-1]) &&
                         (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                // diff msb is the borrow: set exactly when a < b unsigned
                result = diff[DATA_W-1:0];
                c      = diff[DATA_W];
                v      = (a[DATA_W-1] != b[DATA_W-1]) &&
                         (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                c      = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                c      = a[0];
            end
            OP_MOV: result = b;
            default: ;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops, shift-add MUL, flag register,
// and the registered write-back triple for the register file.
module execute_stage
    import exec_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [ADDR_W-1:0] dest,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WriteData,
    output logic              regWriteEnable,
    output logic [3:0]        flags,
    output logic              busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
    localparam int PW    = 2 * DATA_W;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [PW-1:0]       ma_q;
    logic [DATA_W-1:0]   mb_q;
    logic [PW-1:0]       acc_q;
    logic [PW-1:0]       acc_nxt;
    logic [ADDR_W-1:0]   dst_q;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W-1:0]   res;
    logic                alu_c;
    logic                alu_v;
    logic                accept;
    logic                last;

    assign opb      = use_imm ? imm : rd2;
    assign in_ready = (state_q != ST_MUL);
    assign busy     = (state_q == ST_MUL);
    assign accept   = in_valid && in_ready;
    assign last     = (state_q == ST_MUL) &&
                      (cnt_q == CNT_W'(MUL_CYCLES - 1));
    assign acc_nxt  = acc_q + (mb_q[0] ? ma_q : '0);

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (rd1),
        .b      (opb),
        .result (res),
        .c      (alu_c),
        .v      (alu_v)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && op == OP_MUL) state_d = ST_MUL;
            ST_MUL:  if (last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            ma_q           <= '0;
            mb_q           <= '0;
            acc_q          <= '0;
            dst_q          <= '0;
            A3             <= '0;
            WriteData      <= '0;
            regWriteEnable <= 1'b0;
            flags          <= '0;
        end else begin
            state_q        <= state_d;
            regWriteEnable <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (accept && op == OP_MUL) begin
                    ma_q  <= {{DATA_W{1'b0}}, rd1};
                    mb_q  <= opb;
                    acc_q <= '0;
                    cnt_q <= '0;
                    dst_q <= dest;
                end else if (accept && op <= OP_CMP) begin
                    flags[FLAG_N] <= res[DATA_W-1];
                    flags[FLAG_Z] <= (res == '0);
                    flags[FLAG_C] <= alu_c;
                    flags[FLAG_V] <= alu_v;
                    if (op != OP_CMP) begin
                        A3             <= dest;
                        WriteData      <= res;
                        regWriteEnable <= 1'b1;
                    end
                end
            end else begin
                acc_q <= acc_nxt;
                ma_q  <= ma_q << 1;
                mb_q  <= mb_q >> 1;
                cnt_q <= cnt_q + 1'b1;
                if (last) begin
                    A3             <= dst_q;
                    WriteData      <= acc_nxt[DATA_W-1:0];
                    regWriteEnable <= 1'b1;
                    flags[FLAG_N]  <= acc_nxt[DATA_W-1];
                    flags[FLAG_Z]  <= (acc_nxt[DATA_W-1:0] == '0);
                    flags[FLAG_C]  <= |acc_nxt[PW-1:DATA_W];
                    flags[FLAG_V]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 8-bit microprocessor, directly downstream of the register file.
- Consumes the two register read values plus an optional immediate, computes the ALU result, and produces the write-back triple (address, data, write enable) that drives the register file's A3 / WriteData / regWriteEnable inputs.
- Single-cycle ALU ops run back-to-back. MUL is an 8-cycle shift-add sequence. Condition flags are held in a register.

Parameters:
- DATA_W, 8, datapath width.
- ADDR_W, 8, register address width (matches register file A1/A2/A3).
- MUL_CYCLES, 8, multiply iteration count (must equal DATA_W).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- op  in  4  opcode (see package)
- rd1  in  DATA_W  operand A (register file RD1)
- rd2  in  DATA_W  operand B (register file RD2)
- imm  in  DATA_W  immediate
- use_imm  in  1  1: B = imm, 0: B = rd2
- dest  in  ADDR_W  write-back register address
- A3  out  ADDR_W  write-back address to register file
- WriteData  out  DATA_W  write-back data
- regWriteEnable  out  1  one-cycle write strobe
- flags  out  4  {N,Z,C,V}
- busy  out  1  high while MUL is iterating

Behaviour:
- Reset (async, rst_n=0): state=IDLE; A3=0, WriteData=0, regWriteEnable=0, flags=0, busy=0, MUL counter=0. in_ready=1 once released.
- Acceptance: an instruction is accepted on a rising edge when in_valid && in_ready. in_ready = (state != MUL). When in_valid=0, nothing changes and regWriteEnable=0 next cycle.
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~A
  - 6 SHL: A<<1, C=A[7]
  - 7 SHR: logical A>>1, C=A[0]
  - 8 MOV: B
  - 9 CMP: A-B, flags only, no write
  - 10 MUL: low byte of A*B
  - 11-15 NOP: no write, flags held
- ALU ops (all except MUL): accepted at edge t. On that edge, A3<=dest, WriteData<=result and regWriteEnable<=1 (0 for CMP/NOP), so the strobe is high for exactly the cycle after t. Flags update on the same edge. A new op may be accepted on the very next edge; the strobe stays high continuously for back-to-back writes.
- Flags:
  - Z = result==0; N = result[7]. Both updated by ops 0-10.
  - C = carry-out for ADD. C = borrow (A<B unsigned) for SUB/CMP. Shift-out bit for SHL/SHR.
  - V = signed overflow for ADD/SUB/CMP.
  - AND/OR/XOR/NOT/MOV clear C and V.
- MUL:
  - Accept at edge t: latch A, B and dest. State goes to MUL, busy=1, counter=0, accumulator=0, regWriteEnable<=0.
  - Each edge in MUL: if B[0], add A to the accumulator. Then shift A left and B right, and increment the counter. Arithmetic is 16-bit internally.
  - On the edge where counter==MUL_CYCLES-1, after that final iteration: state returns to IDLE, busy=0, A3=latched dest, WriteData=low byte, regWriteEnable=1 for one cycle. Z/N come from the low byte; C=(high byte!=0); V=0.
  - in_ready is low for 8 cycles (t+1..t+8) and high in the strobe cycle.
- State machine:
  - IDLE: accepts any op; MUL goes to MUL, all others stay in IDLE.
  - MUL: ignores in_valid; after 8 iterations returns to IDLE.
- Reset mid-MUL aborts the operation: no write strobe is issued and the state returns to IDLE.
- Arithmetic wraps modulo 2^8. Inputs are sampled only on the accept edge.

Decomposition:
- Package exec_pkg holds:
  - opcode localparams OP_ADD..OP_MUL and OP_NOP
  - state encoding ST_IDLE, ST_MUL
  - flag bit indices FLAG_N/Z/C/V
- Sub-module exec_alu: purely combinational, (op, a, b) -> result, c, v.
- The top level holds the FSM, the MUL iterator, the output registers and the flag register.

Test Plan:
- Reset with rst_n=0 mid-run -> all outputs 0 immediately (asynchronous); in_ready=1 after release.
- ADD rd1=200, rd2=100, dest=2 -> next cycle A3=2, WriteData=44, regWriteEnable=1, flags C=1 V=0 Z=0 N=0. The following cycle regWriteEnable=0.
- Back-to-back SUB 5-5 then MOV imm=99 (use_imm=1), dest=4 -> strobe high two consecutive cycles with WriteData 0 (Z=1, C=0) then 99 (Z=0). CMP 3 vs 7 -> no strobe, C=1, N=1.
- MUL 13*11, dest=1 -> in_ready=0 for 8 cycles, busy=1; strobe 9 cycles after accept with WriteData=143, C=0. MUL 16*20 -> WriteData=64, C=1.
- Reset asserted during MUL cycle 4 -> no strobe ever; IDLE after release.
- SHL 0x81 -> WriteData=0x02, C=1. SHR 0x01 -> WriteData=0, Z=1, C=1. Opcode 12 -> no strobe, flags unchanged.
